// File: rtl/neuron_mac_accumulator_if.sv
// Beat/result handshake bundle between the fetch stage, the MAC accumulator and the saturation stage.
interface neuron_mac_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_weight;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dataOUT;
  logic       sign;
  logic       ovf;

  modport master (
    output in_valid, in_data, in_weight, in_last, out_ready,
    input  in_ready, out_valid, dataOUT, sign, ovf
  );

  modport slave (
    input  in_valid, in_data, in_weight, in_last, out_ready,
    output in_ready, out_valid, dataOUT, sign, ovf
  );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Multiply-accumulates signed Q1.6 (data, weight) pairs over one neuron vector and presents the
// rescaled Q1.6 sum with sign and overflow flags for the downstream saturation stage.
//
// state | meaning
// ACC   | accepting beats, accumulating products
// OUT   | result held on dataOUT/sign/ovf until out_ready
module neuron_mac_accumulator #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  parameter int ROUND   = 0
) (
  input logic clk,
  input logic rst_n,
  neuron_mac_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic signed [ACC_W-1:0] POS_LIM   = ACC_W'(64);
  localparam logic signed [ACC_W-1:0] NEG_LIM   = -ACC_W'(64);
  localparam logic signed [ACC_W-1:0] ROUND_ADD = (ROUND != 0) ? ACC_W'(32) : '0;

  typedef enum logic {ACC, OUT} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic                     wrap;
  logic                     wrapSign;
  logic                     outValid;
  logic [7:0]               dataReg;
  logic                     signReg;
  logic                     ovfReg;

  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  prodExt;
  logic signed [ACC_W-1:0]  accNext;
  logic signed [ACC_W-1:0]  scaled;
  logic                     wrapNow;
  logic                     lastBeat;
  logic                     accept;

  assign prod     = $signed(bus.in_data) * $signed(bus.in_weight);
  assign prodExt  = {{(ACC_W-16){prod[15]}}, prod};
  assign accNext  = acc + prodExt;
  assign wrapNow  = (prodExt[ACC_W-1] == acc[ACC_W-1]) && (accNext[ACC_W-1] != acc[ACC_W-1]);
  assign scaled   = (accNext + ROUND_ADD) >>> 6;
  assign lastBeat = bus.in_last || (count == CNT_W'(MAX_LEN - 1));
  assign accept   = bus.in_valid && (state == ACC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      count    <= '0;
      wrap     <= 1'b0;
      wrapSign <= 1'b0;
      outValid <= 1'b0;
      dataReg  <= '0;
      signReg  <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (lastBeat) begin
              // A wrap on the closing beat itself must still be reported.
              dataReg  <= scaled[7:0];
              signReg  <= wrap ? wrapSign : (wrapNow ? prodExt[ACC_W-1] : accNext[ACC_W-1]);
              ovfReg   <= wrap || wrapNow || (scaled > POS_LIM) || (scaled < NEG_LIM);
              outValid <= 1'b1;
              acc      <= '0;
              count    <= '0;
              wrap     <= 1'b0;
              wrapSign <= 1'b0;
              state    <= OUT;
            end else begin
              acc   <= accNext;
              count <= count + CNT_W'(1);
              if (!wrap && wrapNow) begin
                wrap     <= 1'b1;
                wrapSign <= prodExt[ACC_W-1];
              end
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            outValid <= 1'b0;
            state    <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = outValid;
  assign bus.dataOUT   = dataReg;
  assign bus.sign      = signReg;
  assign bus.ovf       = ovfReg;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench: two accumulators (default, and ACC_W=16/MAX_LEN=4/ROUND=1) share one beat stream.
module tb_neuron_mac_accumulator;
  logic       clk = 1'b0;
  logic       rstN;
  logic       inValid, inLast, outReady;
  logic [7:0] inData, inWeight;
  int         nTests = 0;
  int         nFail  = 0;

  neuron_mac_accumulator_if if0 ();
  neuron_mac_accumulator_if if1 ();

  assign if0.in_valid  = inValid;
  assign if0.in_data   = inData;
  assign if0.in_weight = inWeight;
  assign if0.in_last   = inLast;
  assign if0.out_ready = outReady;
  assign if1.in_valid  = inValid;
  assign if1.in_data   = inData;
  assign if1.in_weight = inWeight;
  assign if1.in_last   = inLast;
  assign if1.out_ready = outReady;

  neuron_mac_accumulator #(.ACC_W(24), .MAX_LEN(256), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rstN), .bus(if0.slave)
  );
  neuron_mac_accumulator #(.ACC_W(16), .MAX_LEN(4), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rstN), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nTests++;
    if (obs != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic [7:0] w, input logic last);
    inValid  = 1'b1;
    inData   = d;
    inWeight = w;
    inLast   = last;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic handshake();
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkVal("hs_valid_drop", int'(if0.out_valid), 0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    inValid = 0; inLast = 0; outReady = 0; inData = 0; inWeight = 0; rstN = 0;
    @(posedge clk); #1;
    doReset();
    checkVal("rst_valid", int'(if0.out_valid), 0);
    checkVal("rst_data",  int'(if0.dataOUT), 0);
    checkVal("rst_sign",  int'(if0.sign), 0);
    checkVal("rst_ovf",   int'(if0.ovf), 0);
    checkVal("rst_ready", int'(if0.in_ready), 1);

    // T1: 3 x 1024 = 3072 -> 48
    sendBeat(8'd32, 8'd32, 1'b0);
    sendBeat(8'd32, 8'd32, 1'b0);
    checkVal("t1_not_yet", int'(if0.out_valid), 0);
    sendBeat(8'd32, 8'd32, 1'b1);
    checkVal("t1_valid", int'(if0.out_valid), 1);
    checkVal("t1_data",  int'(if0.dataOUT), 48);
    checkVal("t1_sign",  int'(if0.sign), 0);
    checkVal("t1_ovf",   int'(if0.ovf), 0);
    checkVal("t1_ready", int'(if0.in_ready), 0);
    handshake();
    checkVal("t1_ready_back", int'(if0.in_ready), 1);

    // T2: +128 and -128 overflow
    sendBeat(8'd64, 8'd64, 1'b0);
    sendBeat(8'd64, 8'd64, 1'b1);
    checkVal("t2_pos_ovf",  int'(if0.ovf), 1);
    checkVal("t2_pos_sign", int'(if0.sign), 0);
    handshake();
    sendBeat(8'hC0, 8'd64, 1'b0);
    sendBeat(8'hC0, 8'd64, 1'b1);
    checkVal("t2_neg_ovf",  int'(if0.ovf), 1);
    checkVal("t2_neg_sign", int'(if0.sign), 1);
    handshake();

    // T3: exactly +/-64 is in range
    sendBeat(8'd64, 8'd64, 1'b1);
    checkVal("t3_pos_ovf",  int'(if0.ovf), 0);
    checkVal("t3_pos_data", int'(if0.dataOUT), 8'h40);
    handshake();
    sendBeat(8'hC0, 8'd64, 1'b1);
    checkVal("t3_neg_ovf",  int'(if0.ovf), 0);
    checkVal("t3_neg_data", int'(if0.dataOUT), 8'hC0);
    checkVal("t3_neg_sign", int'(if0.sign), 1);
    handshake();

    // T4: 3 x 16129; wraps at 16 bits, fits at 24 bits (s=756)
    sendBeat(8'd127, 8'd127, 1'b0);
    sendBeat(8'd127, 8'd127, 1'b0);
    sendBeat(8'd127, 8'd127, 1'b1);
    checkVal("t4_w16_ovf",  int'(if1.ovf), 1);
    checkVal("t4_w16_sign", int'(if1.sign), 0);
    checkVal("t4_w24_ovf",  int'(if0.ovf), 1);
    checkVal("t4_w24_sign", int'(if0.sign), 0);
    checkVal("t4_w24_data", int'(if0.dataOUT), 8'hF4);
    handshake();

    // T5: result held while out_ready low, offered beats ignored
    sendBeat(8'd16, 8'd64, 1'b1);
    inValid = 1'b1; inData = 8'd127; inWeight = 8'd127; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkVal("t5_hold_valid", int'(if0.out_valid), 1);
      checkVal("t5_hold_data",  int'(if0.dataOUT), 16);
      checkVal("t5_hold_ready", int'(if0.in_ready), 0);
    end
    inValid = 1'b0; inLast = 1'b0;
    handshake();
    sendBeat(8'd16, 8'd64, 1'b1);
    checkVal("t5_after_data", int'(if0.dataOUT), 16);
    checkVal("t5_after_ovf",  int'(if0.ovf), 0);
    handshake();

    // T6: reset mid-vector discards partial sum
    sendBeat(8'd32, 8'd32, 1'b0);
    sendBeat(8'd32, 8'd32, 1'b0);
    doReset();
    checkVal("t6_rst_valid", int'(if0.out_valid), 0);
    checkVal("t6_rst_data",  int'(if0.dataOUT), 0);
    checkVal("t6_rst_ready", int'(if0.in_ready), 1);
    sendBeat(8'd16, 8'd64, 1'b1);
    checkVal("t6_data", int'(if0.dataOUT), 16);
    checkVal("t6_ovf",  int'(if0.ovf), 0);
    checkVal("t6_w16_data", int'(if1.dataOUT), 16);
    handshake();

    // T7: rounding (p=32) and MAX_LEN forced close
    sendBeat(8'd1, 8'd32, 1'b1);
    checkVal("t7_trunc", int'(if0.dataOUT), 0);
    checkVal("t7_round", int'(if1.dataOUT), 1);
    handshake();
    sendBeat(8'd1, 8'd64, 1'b0);
    sendBeat(8'd1, 8'd64, 1'b0);
    sendBeat(8'd1, 8'd64, 1'b0);
    checkVal("t7_len3_open", int'(if1.out_valid), 0);
    sendBeat(8'd1, 8'd64, 1'b0);
    checkVal("t7_len4_close", int'(if1.out_valid), 1);
    checkVal("t7_len4_data",  int'(if1.dataOUT), 4);
    checkVal("t7_len4_ovf",   int'(if1.ovf), 0);
    checkVal("t7_w24_open",   int'(if0.out_valid), 0);
    handshake();
    doReset();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
